// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//   mode select constants and the controller state encoding.
package serial_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Request/result bundle of the digit-serial adder/subtractor.
//   master : drives start, A, B, C (mode); observes busy, done, S, cout, ovf
//   slave  : the arithmetic block itself
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    modport master (
        output start, A, B, C,
        input  busy, done, S, cout, ovf
    );

    modport slave (
        input  start, A, B, C,
        output busy, done, S, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_digit_rca.sv
// digit_rca
//   Combinational DIGIT-bit ripple-carry adder.
//   a, b   : digit operands
//   cin    : carry into bit 0
//   sum    : digit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module digit_rca #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    import serial_addsub_pkg::*;

    always_comb begin
        logic [DIGIT:0] c;
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor, DIGIT bits per cycle, LSB first.
//   clk     : single clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : slave side of serial_addsub_if (start/A/B/C in,
//             busy/done/S/cout/ovf out)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | one digit added per cycle, WIDTH/DIGIT cycles
//   DONE    | result valid, done pulse; start here chains a new op
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_addsub_if.slave bus
);
    import serial_addsub_pkg::*;

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   s_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               load;
    logic               step;
    logic               last;
    logic               busy_c;
    logic               done_c;

    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic               dig_cmsb;

    assign last  = (cnt_q == CNT_W'(N - 1));
    assign dig_a = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_b = b_q[cnt_q*DIGIT +: DIGIT];

    digit_rca #(
        .DIGIT (DIGIT)
    ) u_rca (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted once at load and the
    // mode bit doubles as the initial carry-in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= bus.A;
            b_q     <= (bus.C == MODE_SUB) ? ~bus.B : bus.B;
            carry_q <= bus.C;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (step) begin
            s_q[cnt_q*DIGIT +: DIGIT] <= dig_sum;
            carry_q                   <= dig_cout;
            cnt_q                     <= cnt_q + CNT_W'(1);
            if (last) begin
                cout_q <= dig_cout;
                ovf_q  <= dig_cout ^ dig_cmsb;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.S    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub_if #(.WIDTH(4)) if0 ();
    serial_addsub_if #(.WIDTH(4)) if1 ();
    serial_addsub_if #(.WIDTH(8)) if2 ();

    serial_addsub #(.WIDTH(4), .DIGIT(1)) u0 (.clk(clk), .reset_n(rst_n), .bus(if0));
    serial_addsub #(.WIDTH(4), .DIGIT(2)) u1 (.clk(clk), .reset_n(rst_n), .bus(if1));
    serial_addsub #(.WIDTH(8), .DIGIT(1)) u2 (.clk(clk), .reset_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        case (sel)
            0: begin if0.start = st; if0.A = a[3:0]; if0.B = b[3:0]; if0.C = c; end
            1: begin if1.start = st; if1.A = a[3:0]; if1.B = b[3:0]; if1.C = c; end
            default: begin if2.start = st; if2.A = a; if2.B = b; if2.C = c; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if0.done;
            1: return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if0.busy;
            1: return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic [31:0] get_s(input int sel);
        case (sel)
            0: return {28'd0, if0.S};
            1: return {28'd0, if1.S};
            default: return {24'd0, if2.S};
        endcase
    endfunction

    function automatic logic [1:0] get_flags(input int sel);
        case (sel)
            0: return {if0.cout, if0.ovf};
            1: return {if1.cout, if1.ovf};
            default: return {if2.cout, if2.ovf};
        endcase
    endfunction

    // Issues one operation, then scrambles the inputs after the start edge.
    // lat counts edges from the start edge up to the cycle showing done.
    task automatic do_op(input string tag, input int sel, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input int exp_lat,
                         input logic [7:0] exp_s, input logic exp_cout,
                         input logic exp_ovf);
        int   lat;
        logic busy1;
        logic [31:0] s_done;
        busy1 = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, a, b, c);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_done(sel)) break;
            if (lat == 1) begin
                busy1 = get_busy(sel);
                drive(sel, 1'b0, ~a, ~b, ~c);
            end
        end
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_busy"}, {31'd0, busy1}, 1);
        check({tag, "_S"},    get_s(sel), {24'd0, exp_s});
        check({tag, "_cout"}, {31'd0, get_flags(sel) >> 1}, {31'd0, exp_cout});
        check({tag, "_ovf"},  {31'd0, get_flags(sel) & 2'b01}, {31'd0, exp_ovf});
        s_done = get_s(sel);
        @(posedge clk);
        #1;
        check({tag, "_done1cyc"}, {31'd0, get_done(sel)}, 0);
        check({tag, "_hold"}, get_s(sel), s_done);
    endtask

    initial begin
        int n_done;
        int first_idx;
        int last_idx;
        logic [31:0] s_at;

        rst_n = 1'b0;
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, if2.busy}, 0);
        check("rst_done", {31'd0, if2.done}, 0);
        check("rst_S",    {24'd0, if2.S}, 0);
        check("rst_flags", {30'd0, if2.cout, if2.ovf}, 0);
        check("rst_S_w4", {28'd0, if0.S}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors, hand-computed
        do_op("w4d1_6p5",   0, 8'd6,   8'd5,   1'b0, 5, 8'b1011, 1'b0, 1'b1);
        do_op("w4d1_3m5",   0, 8'd3,   8'd5,   1'b1, 5, 8'd14,   1'b0, 1'b0);
        do_op("w4d2_6m5",   1, 8'd6,   8'd5,   1'b1, 3, 8'd1,    1'b1, 1'b0);
        do_op("w4d2_7p1",   1, 8'd7,   8'd1,   1'b0, 3, 8'd8,    1'b0, 1'b1);
        do_op("w4d2_8m1",   1, 8'd8,   8'd1,   1'b1, 3, 8'd7,    1'b1, 1'b1);
        do_op("w8_200p100", 2, 8'd200, 8'd100, 1'b0, 9, 8'd44,   1'b1, 1'b0);
        do_op("w8_0m1",     2, 8'd0,   8'd1,   1'b1, 9, 8'hFF,   1'b0, 1'b0);
        do_op("w8_127p1",   2, 8'd127, 8'd1,   1'b0, 9, 8'h80,   1'b0, 1'b1);
        do_op("w8_80m1",    2, 8'h80,  8'd1,   1'b1, 9, 8'h7F,   1'b1, 1'b1);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        drive(2, 1'b1, 8'd200, 8'd100, 1'b0);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 8'd200, 8'd100, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(2, 1'b1, 8'd1, 8'd1, 1'b1);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 8'd1, 8'd1, 1'b1);
        n_done = 0;
        s_at   = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (if2.done) begin
                n_done++;
                s_at = {24'd0, if2.S};
            end
        end
        check("midstart_ndone", n_done, 1);
        check("midstart_S", s_at, 44);
        check("midstart_flags", {30'd0, if2.cout, if2.ovf}, 2);

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        drive(2, 1'b1, 8'd50, 8'd60, 1'b0);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 8'd50, 8'd60, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, if2.busy}, 0);
        check("midrst_done", {31'd0, if2.done}, 0);
        check("midrst_S", {24'd0, if2.S}, 0);
        check("midrst_flags", {30'd0, if2.cout, if2.ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if2.done) n_done++;
        end
        check("midrst_nodone", n_done, 0);
        do_op("w8_3p4", 2, 8'd3, 8'd4, 1'b0, 9, 8'd7, 1'b0, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        drive(2, 1'b1, 8'd10, 8'd20, 1'b0);
        n_done    = 0;
        first_idx = 0;
        last_idx  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (if2.done) begin
                n_done++;
                if (first_idx == 0) first_idx = i;
                last_idx = i;
                check("b2b_S", {24'd0, if2.S}, 30);
            end
        end
        check("b2b_ndone", n_done, 3);
        check("b2b_first", first_idx, 9);
        check("b2b_last", last_idx, 27);
        @(negedge clk);
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (12) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
